gcm_ghash_digit: RTL
====================

Name: gcm_ghash_digit

Overview:
Parametrised GHASH core for AES-GCM: maintains accumulator Y and computes Y <= (Y ^ X) * H in GF(2^128) per SP800-38D (bit-reflected, R = 0xE1 || 0^120).
Digit-serial multiplier processes DIGIT_W multiplier bits per clock, trading area for latency.
Sits between the AES core (supplies H and blocks) and the GCM tag logic (consumes Y).

Parameters:
DIGIT_W, 4, multiplier bits consumed per cycle; legal 1,2,4,8,16; must divide 128 (elaboration error otherwise)
NCYC (localparam), 128/DIGIT_W, compute cycles per block

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
init  in  1  pulse: load hash key H from h, clear Y to 0
next  in  1  pulse: absorb block x
h  in  128  hash key H = AES_K(0^128), sampled on init
x  in  128  data block, sampled on accepted next
y  out  128  accumulator Y (registered)
ready  out  1  1 = idle, can accept init/next
done  out  1  one-cycle pulse when y updated after next

Behaviour:
- Reset (reset_n=0 at rising edge): state IDLE, y=0, h_reg=0, ready=1, done=0, counter=0; overrides everything incl. mid-computation (result discarded).
- States: IDLE, BUSY.
- IDLE, init=1: h_reg<=h, y<=0; stays IDLE, ready stays 1, done=0. init has priority over simultaneous next (next dropped).
- IDLE, next=1 (init=0) at edge k: a_reg<=y^x, v_reg<=h_reg, z_reg<=0, cnt<=0, ready<=0 -> BUSY.
- BUSY per edge: DIGIT_W unrolled steps; step takes a_reg MSB (bit 127 = GCM bit 0): if 1, z^=v; then v = v[0] ? (v>>1)^{8'hE1,120'b0} : v>>1; a_reg shifts left by 1. cnt++.
- At edge k+NCYC (last digit): y<=final z, ready<=1, done<=1 for one cycle, -> IDLE. ready low for exactly NCYC cycles.
- init/next while BUSY ignored (no queuing); h_reg changes never affect in-flight op.
- Back-to-back: next may be asserted in the cycle done=1 (ready=1); accepted there.
- y held stable between updates; y never shows partial products.
- h_reg internal; H change requires init, which clears Y.

Optional Feature:
Macro GHASH_BLOCK_CNT_EN.
- Defined: extra output blk_cnt [31:0]; reset to 0, cleared on init, incremented on each done pulse, wraps 0xFFFFFFFF -> 0; used by tag logic for len(C) cross-check.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Identity: init h=0x80000000_00000000_00000000_00000000; next x=0x0123456789ABCDEF_FEDCBA9876543210 -> after NCYC cycles done=1, y=x.
- Multiply by x^1 with reduction: init h=0x40000000_...0; next x=0x00..01 -> y=0xE1000000_00000000_00000000_00000000.
- GCM TC2: init h=66e94bd4ef8a2c3b884cfa59ca342b2e; next x=0388dace60b6a392f328c2b971b2fe78 -> y=5e2ec746917062882c85b0685353deb7; rerun for DIGIT_W=1,2,4,8,16 and check ready low exactly 128,64,32,16,8 cycles.
- Zero/init priority: init and next same cycle with h=66e9..2e -> y=0, ready stays 1, no done; next x=0 -> y=0.
- Busy/reset: next accepted, assert next and init mid-BUSY -> ignored, result matches single op; second run with reset_n=0 mid-BUSY -> y=0, ready=1, done never pulses; blk_cnt (if enabled) 0 after reset, 1 after one done, 0 after init.

Source files
------------

// File: rtl/gcm_ghash_digit.sv
// gcm_ghash_digit: GHASH core for AES-GCM, Y <= (Y ^ X) * H in GF(2^128),
// bit-reflected convention, digit-serial multiplier consuming DIGIT_W
// multiplier bits per clock (128/DIGIT_W compute cycles per block).
// Optional feature macro: GHASH_BLOCK_CNT_EN adds a 32-bit blk_cnt output
// counting completed blocks since reset/init.

// One bit-serial GHASH step: conditionally fold V into Z, then V = V * x.
module ghash_step (
  input  logic         a_bit,
  input  logic [127:0] z_in,
  input  logic [127:0] v_in,
  output logic [127:0] z_out,
  output logic [127:0] v_out
);
  localparam logic [127:0] R = {8'hE1, 120'b0};

  assign z_out = a_bit ? (z_in ^ v_in) : z_in;
  assign v_out = {1'b0, v_in[127:1]} ^ (v_in[0] ? R : 128'b0);
endmodule

module gcm_ghash_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [127:0] h,
  input  logic [127:0] x,
  output logic [127:0] y,
  output logic         ready,
  output logic         done
`ifdef GHASH_BLOCK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);
  localparam int NCYC = 128 / DIGIT_W;
  localparam int CW   = $clog2(NCYC);

  generate
    if (DIGIT_W != 1 && DIGIT_W != 2 && DIGIT_W != 4 &&
        DIGIT_W != 8 && DIGIT_W != 16) begin : g_bad_digit
      $error("gcm_ghash_digit: DIGIT_W must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [127:0]    h_reg;
  logic [127:0]    a_reg;  // multiplier operand, MSB = next GCM bit to consume
  logic [127:0]    v_reg;  // H * x^i for the current bit position
  logic [127:0]    z_reg;  // partial product, only copied to y when complete
  logic [CW-1:0]   cnt;

  // Unrolled digit: DIGIT_W chained single-bit steps per clock.
  logic [DIGIT_W:0][127:0] z_ch;
  logic [DIGIT_W:0][127:0] v_ch;

  assign z_ch[0] = z_reg;
  assign v_ch[0] = v_reg;

  generate
    for (genvar g = 0; g < DIGIT_W; g++) begin : g_step
      ghash_step u_step (
        .a_bit (a_reg[127-g]),
        .z_in  (z_ch[g]),
        .v_in  (v_ch[g]),
        .z_out (z_ch[g+1]),
        .v_out (v_ch[g+1])
      );
    end
  endgenerate

  // Control FSM plus datapath registers; y only changes on init or completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      y       <= '0;
      h_reg   <= '0;
      a_reg   <= '0;
      v_reg   <= '0;
      z_reg   <= '0;
      cnt     <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
`ifdef GHASH_BLOCK_CNT_EN
      blk_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            // init wins over a simultaneous next; the block is dropped
            h_reg   <= h;
            y       <= '0;
`ifdef GHASH_BLOCK_CNT_EN
            blk_cnt <= '0;
`endif
          end else if (next) begin
            a_reg <= y ^ x;
            v_reg <= h_reg;
            z_reg <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          z_reg <= z_ch[DIGIT_W];
          v_reg <= v_ch[DIGIT_W];
          a_reg <= a_reg << DIGIT_W;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NCYC - 1)) begin
            y       <= z_ch[DIGIT_W];
            ready   <= 1'b1;
            done    <= 1'b1;
            state   <= IDLE;
`ifdef GHASH_BLOCK_CNT_EN
            blk_cnt <= blk_cnt + 32'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
